tl_cntr_param: RTL and testbench

- Parametrised two-road traffic-light controller: Moore FSM plus on-chip phase timer.
- Adds protected left-turn phases, sensor-driven green extension and a flashing night mode.
- Sits between debounced road sensors and the lamp drivers.
- Lamp codes are decoded from the state register; no external timer block is required.

---
 rtl/tl_cntr_param_if.sv | 23 ++
 rtl/tl_cntr_param.sv | 122 ++++++++++++
 tb/tb_tl_cntr_param.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/tl_cntr_param_if.sv
// Sensor-in / lamp-out bundle of the traffic-light controller.
// The sensor side is the master; the controller is the slave.
interface tl_cntr_param_if;
  logic       ta;
  logic       tb;
  logic       la_req;
  logic       lb_req;
  logic       flash;
  logic [1:0] la;
  logic [1:0] lb;
  logic       flash_blink;
  logic [3:0] state;

  modport master (
    output ta, tb, la_req, lb_req, flash,
    input  la, lb, flash_blink, state
  );

  modport slave (
    input  ta, tb, la_req, lb_req, flash,
    output la, lb, flash_blink, state
  );
endinterface

// File: rtl/tl_cntr_param.sv
// Two-road traffic-light controller: Moore FSM with protected lefts, green extension and flash mode.
// Lamps decode the state register with zero latency; no backpressure, inputs are sampled every cycle.
module tl_cntr_param #(
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int LEFT_T   = 4,
  parameter int FLASH_T  = 2
) (
  input logic            clk,
  input logic            reset_n,
  tl_cntr_param_if.slave bus
);

  localparam logic [3:0] S_A_G   = 4'd0;
  localparam logic [3:0] S_A_Y   = 4'd1;
  localparam logic [3:0] S_A_L   = 4'd2;
  localparam logic [3:0] S_A_LY  = 4'd3;
  localparam logic [3:0] S_B_G   = 4'd4;
  localparam logic [3:0] S_B_Y   = 4'd5;
  localparam logic [3:0] S_B_L   = 4'd6;
  localparam logic [3:0] S_B_LY  = 4'd7;
  localparam logic [3:0] S_FLASH = 4'd8;

  localparam logic [1:0] L_GREEN  = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_RED    = 2'b10;
  localparam logic [1:0] L_ARROW  = 2'b11;

  localparam logic [CNT_W-1:0] GREEN_END  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] LEFT_END   = CNT_W'(LEFT_T - 1);
  localparam logic [CNT_W-1:0] FLASH_END  = CNT_W'(FLASH_T - 1);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             la_pend_q, la_pend_d;
  logic             lb_pend_q, lb_pend_d;
  logic             blink_q, blink_d;
  logic             green_done, yellow_done, left_done, flash_done;
  logic [1:0]       la_c, lb_c;

  assign green_done  = (timer_q == GREEN_END);
  assign yellow_done = (timer_q == YELLOW_END);
  assign left_done   = (timer_q == LEFT_END);
  assign flash_done  = (timer_q == FLASH_END);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_A_G;
      timer_q   <= '0;
      la_pend_q <= 1'b0;
      lb_pend_q <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      la_pend_q <= la_pend_d;
      lb_pend_q <= lb_pend_d;
      blink_q   <= blink_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_A_G:   if (bus.flash || (green_done && (!bus.ta || bus.tb || la_pend_q || lb_pend_q)))
                 state_d = S_A_Y;
      S_A_Y:   if (yellow_done) state_d = bus.flash ? S_FLASH : (la_pend_q ? S_A_L : S_B_G);
      S_A_L:   if (bus.flash || left_done) state_d = S_A_LY;
      S_A_LY:  if (yellow_done) state_d = bus.flash ? S_FLASH : S_B_G;
      S_B_G:   if (bus.flash || (green_done && (!bus.tb || bus.ta || la_pend_q || lb_pend_q)))
                 state_d = S_B_Y;
      S_B_Y:   if (yellow_done) state_d = bus.flash ? S_FLASH : (lb_pend_q ? S_B_L : S_A_G);
      S_B_L:   if (bus.flash || left_done) state_d = S_B_LY;
      S_B_LY:  if (yellow_done) state_d = bus.flash ? S_FLASH : S_A_G;
      S_FLASH: if (!bus.flash) state_d = S_A_G;
      default: state_d = S_A_G;
    endcase
  end

  // Timer, blink phase and left-request latches follow the chosen transition.
  always_comb begin
    timer_d = timer_q + CNT_W'(1);
    blink_d = 1'b0;
    if (state_d != state_q) begin
      timer_d = '0;
      blink_d = (state_d == S_FLASH);
    end else if (state_q == S_FLASH) begin
      blink_d = blink_q ^ flash_done;
      if (flash_done) timer_d = '0;
    end else if ((state_q == S_A_G || state_q == S_B_G) && green_done) begin
      timer_d = timer_q;
    end

    la_pend_d = la_pend_q | (bus.la_req && state_q != S_A_L && state_q != S_A_LY);
    if (state_d == S_A_L && state_q != S_A_L) la_pend_d = 1'b0;
    lb_pend_d = lb_pend_q | (bus.lb_req && state_q != S_B_L && state_q != S_B_LY);
    if (state_d == S_B_L && state_q != S_B_L) lb_pend_d = 1'b0;
  end

  always_comb begin
    la_c = L_RED;
    lb_c = L_RED;
    case (state_q)
      S_A_G:           la_c = L_GREEN;
      S_A_Y, S_A_LY:   la_c = L_YELLOW;
      S_A_L:           la_c = L_ARROW;
      S_B_G:           lb_c = L_GREEN;
      S_B_Y, S_B_LY:   lb_c = L_YELLOW;
      S_B_L:           lb_c = L_ARROW;
      S_FLASH:         la_c = L_YELLOW;
      default:         ;
    endcase
  end

  assign bus.la          = la_c;
  assign bus.lb          = lb_c;
  assign bus.flash_blink = blink_q && (state_q == S_FLASH);
  assign bus.state       = state_q;

endmodule

// File: tb/tb_tl_cntr_param.sv
// Bench for tl_cntr_param: directed vector table, reset sequence, then random traffic against a phase model.
module tb_tl_cntr_param;
  localparam int GREEN_T  = 4;
  localparam int YELLOW_T = 2;
  localparam int LEFT_T   = 3;
  localparam int FLASH_T  = 2;

  localparam int PG = 0, PY = 1, PL = 2, PLY = 3, PF = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   model_on = 1'b0;

  tl_cntr_param_if bus();

  tl_cntr_param #(
    .CNT_W(8), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T), .LEFT_T(LEFT_T), .FLASH_T(FLASH_T)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ta, tb, lar, lbr, fl;
    logic [3:0] st;
    logic [1:0] la, lb;
    logic       bl;
  } vec_t;

  vec_t vecs[$];

  // Model: which road owns the phase, which kind of phase, cycles spent in it.
  int         m_phase = PG;
  bit         m_road  = 1'b0;
  int         m_t     = 0;
  bit         m_blink = 1'b0;
  logic [1:0] m_pend  = 2'b00;
  logic [1:0] trf, req;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int rep, input bit ta, input bit tb, input bit lar, input bit lbr,
                     input bit fl, input int st, input int la, input int lb, input bit bl);
    vec_t v;
    v.ta = ta; v.tb = tb; v.lar = lar; v.lbr = lbr; v.fl = fl;
    v.st = 4'(st); v.la = 2'(la); v.lb = 2'(lb); v.bl = bl;
    repeat (rep) vecs.push_back(v);
  endtask

  function automatic logic pend_next(input bit r, input int np, input bit nr);
    if (np == PL && m_phase != PL && nr == r) return 1'b0;
    if (req[r] && !((m_phase == PL || m_phase == PLY) && m_road == r)) return 1'b1;
    return m_pend[r];
  endfunction

  task automatic model_step();
    int np;
    bit nr;
    bit fl;
    if (!reset_n) begin
      m_phase = PG; m_road = 1'b0; m_t = 0; m_blink = 1'b0; m_pend = 2'b00;
      return;
    end
    trf = {bus.tb, bus.ta};
    req = {bus.lb_req, bus.la_req};
    fl  = bus.flash;
    np  = m_phase;
    nr  = m_road;
    case (m_phase)
      PG:  if (fl || (m_t >= GREEN_T - 1 && (!trf[m_road] || trf[!m_road] || m_pend != 2'b00)))
             np = PY;
      PY:  if (m_t == YELLOW_T - 1) begin
             if (fl) np = PF;
             else if (m_pend[m_road]) np = PL;
             else begin np = PG; nr = !m_road; end
           end
      PL:  if (fl || m_t == LEFT_T - 1) np = PLY;
      PLY: if (m_t == YELLOW_T - 1) begin
             if (fl) np = PF;
             else begin np = PG; nr = !m_road; end
           end
      default: if (!fl) begin np = PG; nr = 1'b0; end
    endcase
    m_pend = {pend_next(1'b1, np, nr), pend_next(1'b0, np, nr)};
    if (np != m_phase || nr != m_road) begin
      m_blink = (np == PF);
      m_t = 0;
    end else if (m_phase == PF) begin
      if (m_t == FLASH_T - 1) begin m_blink = !m_blink; m_t = 0; end
      else m_t++;
    end else begin
      m_t++;
    end
    m_phase = np;
    m_road  = nr;
  endtask

  function automatic logic [8:0] model_vec();
    logic [1:0] own, la, lb;
    if (m_phase == PF) return {4'd8, 2'd1, 2'd2, m_blink};
    own = (m_phase == PG) ? 2'd0 : (m_phase == PL) ? 2'd3 : 2'd1;
    la  = (m_road == 1'b0) ? own : 2'd2;
    lb  = (m_road == 1'b1) ? own : 2'd2;
    return {1'b0, m_road, 2'(m_phase), la, lb, m_blink};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (model_on) begin
      chk("model", int'({bus.state, bus.la, bus.lb, bus.flash_blink}), int'(model_vec()));
      chk("one_road_only", int'(bus.la != 2'b10 && bus.lb != 2'b10), 0);
    end
  endtask

  initial begin
    bus.ta = 1'b0; bus.tb = 1'b0; bus.la_req = 1'b0; bus.lb_req = 1'b0; bus.flash = 1'b0;

    // rep, ta tb lar lbr fl, state la lb blink
    add(20, 1,0,0,0,0, 0, 0,2,0);
    add(2,  1,1,0,0,0, 1, 1,2,0);
    add(4,  1,1,0,0,0, 4, 2,0,0);
    add(2,  1,1,0,0,0, 5, 2,1,0);
    add(1,  1,1,0,0,0, 0, 0,2,0);
    add(1,  1,0,1,0,0, 0, 0,2,0);
    add(2,  1,1,0,0,0, 0, 0,2,0);
    add(2,  1,1,0,0,0, 1, 1,2,0);
    add(1,  1,1,1,0,0, 2, 3,2,0);
    add(2,  0,1,0,0,0, 2, 3,2,0);
    add(2,  0,1,0,0,0, 3, 1,2,0);
    add(6,  0,1,0,0,0, 4, 2,0,0);
    add(2,  1,1,0,0,0, 5, 2,1,0);
    add(6,  1,0,0,0,0, 0, 0,2,0);
    add(1,  1,0,1,0,0, 0, 0,2,0);
    add(2,  1,0,0,0,0, 1, 1,2,0);
    add(1,  1,0,0,0,0, 2, 3,2,0);
    add(2,  1,0,0,0,1, 3, 1,2,0);
    add(2,  1,0,0,0,1, 8, 1,2,1);
    add(2,  1,0,0,0,1, 8, 1,2,0);
    add(2,  1,0,0,0,1, 8, 1,2,1);
    add(1,  1,0,0,0,0, 0, 0,2,0);
    add(2,  1,0,0,0,1, 1, 1,2,0);
    add(1,  1,0,0,0,1, 8, 1,2,1);
    add(1,  1,0,0,0,0, 0, 0,2,0);
    add(1,  1,0,0,1,0, 0, 0,2,0);
    add(2,  1,0,0,0,0, 0, 0,2,0);
    add(2,  1,0,0,0,0, 1, 1,2,0);
    add(4,  1,0,0,0,0, 4, 2,0,0);
    add(2,  1,0,0,0,0, 5, 2,1,0);
    add(1,  1,0,0,0,0, 6, 2,3,0);

    @(negedge clk);
    cycle();
    cycle();
    chk("reset.state", int'(bus.state), 0);
    chk("reset.la", int'(bus.la), 0);
    chk("reset.lb", int'(bus.lb), 2);
    chk("reset.blink", int'(bus.flash_blink), 0);
    model_on = 1'b1;
    reset_n  = 1'b1;

    foreach (vecs[i]) begin
      bus.ta = vecs[i].ta; bus.tb = vecs[i].tb;
      bus.la_req = vecs[i].lar; bus.lb_req = vecs[i].lbr; bus.flash = vecs[i].fl;
      cycle();
      chk($sformatf("vec%0d.state", i), int'(bus.state), int'(vecs[i].st));
      chk($sformatf("vec%0d.la", i), int'(bus.la), int'(vecs[i].la));
      chk($sformatf("vec%0d.lb", i), int'(bus.lb), int'(vecs[i].lb));
      chk($sformatf("vec%0d.blink", i), int'(bus.flash_blink), int'(vecs[i].bl));
    end

    // Reset from B_L: two cycles low, then the green timer must restart from zero.
    bus.ta = 1'b1; bus.tb = 1'b1; bus.la_req = 1'b0; bus.lb_req = 1'b0; bus.flash = 1'b0;
    reset_n = 1'b0;
    cycle();
    chk("bl_reset.state", int'(bus.state), 0);
    chk("bl_reset.la", int'(bus.la), 0);
    chk("bl_reset.lb", int'(bus.lb), 2);
    cycle();
    chk("bl_reset2.state", int'(bus.state), 0);
    reset_n = 1'b1;
    for (int k = 0; k < GREEN_T - 1; k++) begin
      cycle();
      chk($sformatf("post_reset_green%0d", k), int'(bus.state), 0);
    end
    cycle();
    chk("post_reset_yellow", int'(bus.state), 1);

    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 7) == 0) bus.ta = ~bus.ta;
      if ($urandom_range(0, 7) == 0) bus.tb = ~bus.tb;
      bus.la_req = ($urandom_range(0, 15) == 0);
      bus.lb_req = ($urandom_range(0, 15) == 0);
      if (bus.flash) bus.flash = ($urandom_range(0, 39) != 0);
      else           bus.flash = ($urandom_range(0, 199) == 0);
      reset_n = ($urandom_range(0, 2999) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
